// File: rtl/pilot_fifo_ctrl.sv
// pilot_fifo_ctrl: synchronous FIFO with req/ack echo and a software register window.
// Error flags, ERRCLR and irq are built only when PILOT_FIFO_ERR_EN is defined.
module pilot_fifo_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    output logic             ack,
    input  logic             fifo_push,
    input  logic [WIDTH-1:0] fifo_wdata,
    input  logic             fifo_pop,
    output logic [WIDTH-1:0] fifo_rdata,
    output logic             valid,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             almost_full,
    input  logic             sw_we,
    input  logic [31:0]      sw_addr,
    input  logic [31:0]      sw_wdata,
    output logic [31:0]      sw_rdata,
    output logic             irq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] A_STATUS = 32'h0;
    localparam logic [31:0] A_CTRL   = 32'h4;
    localparam logic [31:0] A_ERRCLR = 32'h8;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             en;
    logic [7:0]       thresh;
    logic             ctrl_we;
    logic             flush;
    logic             push_ok;
    logic             pop_ok;
    logic             ovf;
    logic             unf;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^{sw_wdata[31:16], sw_wdata[7:2]};

    assign fifo_full   = count == CNT_W'(DEPTH);
    assign fifo_empty  = count == '0;
    assign almost_full = 32'(count) >= 32'(thresh);

    assign ctrl_we = sw_we && (sw_addr == A_CTRL);
    assign flush   = ctrl_we && sw_wdata[1];
    assign pop_ok  = en && fifo_pop && !fifo_empty;
    assign push_ok = en && fifo_push && (!fifo_full || pop_ok);

    always_comb begin
        rd_mux = '0;
        case (sw_addr)
            A_STATUS: begin
                rd_mux[CNT_W-1:0] = count;
                rd_mux[16]        = fifo_full;
                rd_mux[17]        = fifo_empty;
                rd_mux[18]        = ovf;
                rd_mux[19]        = unf;
            end
            A_CTRL: begin
                rd_mux[0]    = en;
                rd_mux[15:8] = thresh;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack        <= 1'b0;
            valid      <= 1'b0;
            fifo_rdata <= '0;
            sw_rdata   <= '0;
            en         <= 1'b0;
            thresh     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            ack      <= req;
            sw_rdata <= rd_mux;
            valid    <= pop_ok && !flush;
            if (ctrl_we) begin
                en     <= sw_wdata[0];
                thresh <= sw_wdata[15:8];
            end
            // flush wins over any same-cycle push or pop
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop_ok) begin
                    fifo_rdata <= mem[rd_ptr];
                    rd_ptr     <= rd_ptr + AW'(1);
                end
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (push_ok && !pop_ok) begin
                    count <= count + CNT_W'(1);
                end else if (pop_ok && !push_ok) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= fifo_wdata;
        end
    end

`ifdef PILOT_FIFO_ERR_EN
    logic errclr_we;
    logic ovf_nxt;
    logic unf_nxt;
    logic irq_q;

    assign errclr_we = sw_we && (sw_addr == A_ERRCLR);

    // a new error event beats a same-cycle clear
    always_comb begin
        ovf_nxt = ovf;
        unf_nxt = unf;
        if (errclr_we && sw_wdata[0]) ovf_nxt = 1'b0;
        if (errclr_we && sw_wdata[1]) unf_nxt = 1'b0;
        if (fifo_push && fifo_full && !pop_ok) ovf_nxt = 1'b1;
        if (fifo_pop && fifo_empty) unf_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf   <= 1'b0;
            unf   <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
            irq_q <= ovf_nxt | unf_nxt;
        end
    end

    assign irq = irq_q;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pilot_fifo_ctrl.sv
// Scoreboard bench for pilot_fifo_ctrl: directed test plan, then randomized traffic
// checked against a queue-based reference model.
module tb_pilot_fifo_ctrl;
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        ack;
    logic        fifo_push;
    logic [31:0] fifo_wdata;
    logic        fifo_pop;
    logic [31:0] fifo_rdata;
    logic        valid;
    logic        fifo_full;
    logic        fifo_empty;
    logic        almost_full;
    logic        sw_we;
    logic [31:0] sw_addr;
    logic [31:0] sw_wdata;
    logic [31:0] sw_rdata;
    logic        irq;

    pilot_fifo_ctrl #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .fifo_push(fifo_push), .fifo_wdata(fifo_wdata),
        .fifo_pop(fifo_pop), .fifo_rdata(fifo_rdata), .valid(valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .sw_we(sw_we), .sw_addr(sw_addr),
        .sw_wdata(sw_wdata), .sw_rdata(sw_rdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PILOT_FIFO_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    bit          m_en, m_ovf, m_unf, m_valid, m_ack, m_irq, started;
    logic [7:0]  m_th;
    logic [31:0] m_rdata, m_sw;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a plain queue, flags derive from its size.
    always @(posedge clk) begin
        int  cnt;
        bit  full, empty, popok, pushok, flush;
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            m_en = 0; m_th = 0; m_ovf = 0; m_unf = 0; m_valid = 0;
            m_ack = 0; m_irq = 0; m_rdata = 0; m_sw = 0;
            started = 1;
        end else begin
            cnt   = mq.size();
            full  = (cnt == DEPTH);
            empty = (cnt == 0);
            m_sw  = 0;
            if (sw_addr == 32'h0) begin
                m_sw = 32'(cnt);
                m_sw[16] = full;
                m_sw[17] = empty;
                m_sw[18] = m_ovf;
                m_sw[19] = m_unf;
            end else if (sw_addr == 32'h4) begin
                m_sw = {16'h0, m_th, 7'h0, m_en};
            end
            popok  = m_en && fifo_pop && !empty;
            pushok = m_en && fifo_push && (!full || popok);
            flush  = sw_we && sw_addr == 32'h4 && sw_wdata[1];
            if (ERR) begin
                if (sw_we && sw_addr == 32'h8 && sw_wdata[0]) m_ovf = 0;
                if (sw_we && sw_addr == 32'h8 && sw_wdata[1]) m_unf = 0;
                if (fifo_push && full && !popok) m_ovf = 1;
                if (fifo_pop && empty) m_unf = 1;
                m_irq = m_ovf | m_unf;
            end
            m_valid = 0;
            if (flush) begin
                mq.delete();
            end else begin
                if (popok) begin
                    m_rdata = mq.pop_front();
                    exp_q.push_back(m_rdata);
                    m_valid = 1;
                end
                if (pushok) mq.push_back(fifo_wdata);
            end
            if (sw_we && sw_addr == 32'h4) begin
                m_en = sw_wdata[0];
                m_th = sw_wdata[15:8];
            end
            m_ack = req;
        end
    end

    // Monitor: pops expected data whenever the DUT presents valid.
    always @(negedge clk) begin
        if (started) begin
            chk("valid", 32'(valid), 32'(m_valid));
            if (valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid actual=1 expected=0 t=%0t", $time);
                end else if (fifo_rdata !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rdata actual=%h expected=%h t=%0t",
                             fifo_rdata, exp_q[0], $time);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            chk("rdata_hold", fifo_rdata, m_rdata);
            chk("full", 32'(fifo_full), 32'(mq.size() == DEPTH));
            chk("empty", 32'(fifo_empty), 32'(mq.size() == 0));
            chk("almost_full", 32'(almost_full), 32'(mq.size() >= int'(m_th)));
            chk("ack", 32'(ack), 32'(m_ack));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("sw_rdata", sw_rdata, m_sw);
        end
    end

    task automatic cyc(input bit ps, input logic [31:0] wd, input bit pp,
                       input bit we, input logic [31:0] a, input logic [31:0] w);
        fifo_push  = ps;
        fifo_wdata = wd;
        fifo_pop   = pp;
        sw_we      = we;
        sw_addr    = a;
        sw_wdata   = w;
        req        = 1'($urandom_range(0, 1));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, w;
        rst_n = 0; req = 0; fifo_push = 0; fifo_wdata = 0; fifo_pop = 0;
        sw_we = 0; sw_addr = 0; sw_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_empty", 32'(fifo_empty), 32'h1);
        chk("rst_full", 32'(fifo_full), 32'h0);
        chk("rst_af", 32'(almost_full), 32'h1);
        rst_n = 1;
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("rst_status", sw_rdata, 32'h0002_0000);

        cyc(0, 0, 0, 1, 32'h4, 32'h0000_0601);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'h11 + i, 0, 0, 32'h0, 0);
            if (i == 4) chk("af_below", 32'(almost_full), 32'h0);
            if (i == 5) chk("af_at6", 32'(almost_full), 32'h1);
            if (i == 6) chk("not_full7", 32'(fifo_full), 32'h0);
        end
        chk("full8", 32'(fifo_full), 32'h1);
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("status_cnt8", sw_rdata, 32'h0001_0008);

        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, 32'h0, 0);
            chk("pop_valid", 32'(valid), 32'h1);
            chk("pop_seq", fifo_rdata, 32'h11 + i);
        end
        chk("empty_end", 32'(fifo_empty), 32'h1);
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("valid_drop", 32'(valid), 32'h0);
        chk("rdata_held", fifo_rdata, 32'h18);

        for (int i = 0; i < 8; i++) cyc(1, 32'h21 + i, 0, 0, 32'h0, 0);
        cyc(1, 32'h99, 1, 0, 32'h0, 0);
        chk("pp_full_oldest", fifo_rdata, 32'h21);
        chk("pp_full_still", 32'(fifo_full), 32'h1);
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("pp_full_status", sw_rdata, 32'h0001_0008);

        cyc(1, 32'hAA, 0, 0, 32'h0, 0);
        chk("ovf_irq", 32'(irq), 32'(ERR));
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("ovf_status", sw_rdata, ERR ? 32'h0005_0008 : 32'h0001_0008);
        cyc(0, 0, 0, 1, 32'h8, 32'h1);
        chk("errclr_irq", 32'(irq), 32'h0);
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("errclr_status", sw_rdata, 32'h0001_0008);

        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 32'h0, 0);
        cyc(1, 32'h77, 0, 1, 32'h4, 32'h0000_0003);
        chk("flush_empty", 32'(fifo_empty), 32'h1);
        chk("flush_valid", 32'(valid), 32'h0);
        cyc(0, 0, 0, 0, 32'h4, 0);
        chk("flush_ctrl", sw_rdata, 32'h0000_0001);
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("flush_status", sw_rdata, 32'h0002_0000);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_n = 0;
                cyc(1, $urandom, 1, 0, 32'h0, 0);
                cyc(0, 0, 0, 0, 32'h0, 0);
                rst_n = 1;
                cyc(0, 0, 0, 1, 32'h4, 32'h0000_0501);
            end
            case ($urandom_range(0, 3))
                0: a = 32'h0;
                1: a = 32'h4;
                2: a = 32'h8;
                default: a = $urandom;
            endcase
            w = $urandom;
            if (a == 32'h4) begin
                w = {16'h0, 8'($urandom_range(0, DEPTH + 2)), 6'h0,
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0)};
            end
            cyc($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
                $urandom_range(0, 19) == 0, a, w);
        end
        cyc(0, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pilot_fifo_ctrl.md
# pilot_fifo_ctrl

Parametrised successor to the pilot top-level block. It provides a real synchronous FIFO of configurable width and depth, replacing the tied-off full/empty stub. It keeps the registered req/ack echo and exposes a small software register window with a control register, status readback and an almost-full threshold. It sits at the pilot top level between the stimulus source and the downstream consumer.

## Interface
Parameters:
- WIDTH, 32: FIFO data width in bits (1..32).
- DEPTH, 8: FIFO entries; power of two, 2..256.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  1  request strobe.
- ack  out  1  registered echo of req.
- fifo_push  in  1  push request.
- fifo_wdata  in  WIDTH  push data.
- fifo_pop  in  1  pop request.
- fifo_rdata  out  WIDTH  popped data, registered.
- valid  out  1  fifo_rdata holds data from a pop accepted last cycle.
- fifo_full  out  1  occupancy == DEPTH.
- fifo_empty  out  1  occupancy == 0.
- almost_full  out  1  occupancy >= CTRL.thresh.
- sw_we  in  1  register write strobe.
- sw_addr  in  32  register byte address.
- sw_wdata  in  32  register write data.
- sw_rdata  out  32  registered read data for sw_addr.
- irq  out  1  error interrupt (see Configuration).

## Operation
- Registers:
  - 0x0 STATUS (RO): [CNT_W-1:0] count, [16] full, [17] empty, [18] overflow, [19] underflow.
  - 0x4 CTRL (RW): [0] enable, [1] flush (self-clearing, reads 0), [15:8] thresh.
  - 0x8 ERRCLR (WO): writing 1 to bit 0 clears overflow; writing 1 to bit 1 clears underflow.
  - Other addresses read 0; writes to them are ignored.
- Accepted push: enable && fifo_push && (!fifo_full || accepted pop).
- Accepted pop: enable && fifo_pop && !fifo_empty. There is no bypass: a push and a pop into an empty FIFO accept only the push.
- Full with push and pop together: both are accepted and count is unchanged.
- Flush (CTRL write with bit1=1): the pointers and count clear on that edge. Flush overrides any push or pop in the same cycle; valid is 0 on the next cycle.
- enable=0: push and pop are ignored, contents are held, and flags still reflect count.
- Overflow sets on fifo_push && fifo_full && no accepted pop. Underflow sets on fifo_pop && fifo_empty. Both flags are sticky.
- If ERRCLR and a new error event occur in the same cycle, the set wins.
- Pointers are log2(DEPTH) bits and wrap naturally. count is a separate CNT_W-bit counter.
- thresh is compared zero-extended. thresh=0 makes almost_full constantly 1.

## Timing
- Reset values: ack=0, valid=0, fifo_rdata=0, sw_rdata=0, irq=0, CTRL=0 (disabled, thresh 0), count=0, pointers=0.
  - After reset, fifo_empty=1, fifo_full=0 and almost_full=1.
- rst_n asserted mid-operation discards contents on the next edge. RAM contents are don't-care.
- ack(t+1) = req(t).
- Pop accepted at edge t: fifo_rdata and valid=1 appear after edge t. Without a further pop, valid drops the following cycle and fifo_rdata holds its value.
- fifo_full, fifo_empty and almost_full are combinational from the registered count, so they update the cycle after a push or pop.
- sw_rdata: one-cycle latency from sw_addr and reflects register state before any same-edge write.
- A CTRL write takes effect on the next cycle's accept decisions.

## Configuration
- PILOT_FIFO_ERR_EN defined: overflow/underflow flags, ERRCLR and irq are implemented, with irq = overflow | underflow registered.
- PILOT_FIFO_ERR_EN undefined: STATUS[19:18] read 0, ERRCLR writes are ignored, irq is tied to 0. No error-flag flops are present.

## Test plan
- Reset, then read 0x0 -> sw_rdata = 0x0002_0000 (empty set); ack=0, valid=0, irq=0.
- Write CTRL=0x0000_0601 (enable, thresh 6); push 0x11..0x18 (DEPTH=8) -> fifo_full=1 after the 8th push, almost_full=1 after the 6th; STATUS count=8.
- Pop 8 times -> fifo_rdata sequence 0x11..0x18 each with valid=1 one cycle after the pop; fifo_empty=1 at the end.
- Fill to 8, then push and pop together -> count stays 8, the popped value is the oldest, overflow stays 0.
- With PILOT_FIFO_ERR_EN: push while full without pop -> STATUS[18]=1 and irq=1 the next cycle; write ERRCLR=1 -> both clear. Without the macro -> both stay 0.
- Fill 5 entries, then write CTRL=0x0000_0003 (enable+flush) while pushing -> count=0 and fifo_empty=1 next cycle, the push is dropped, and CTRL reads back 0x0000_0001.
